// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: ratio/enable controller for the programmable clock divider.
// Applies ratio changes glitch-free: gate off, drain one old period, load, settle.
//
// Ports:
//   i_ref_clk    reference clock shared with the divider
//   i_rst        async active-high reset (deassert synchronously to i_ref_clk)
//   i_run        request to run the divided clock (sampled only in RUN)
//   i_req_valid  ratio-change request valid
//   i_req_ratio  requested ratio (sampled at acceptance)
//   o_req_ready  high in RUN only
//   o_div_ratio  registered ratio to the divider
//   o_clk_en     registered enable to the divider
//   o_busy       ratio change in progress
//   o_done       1-cycle pulse on request completion
//   o_err        1-cycle pulse on rejected request (ratio 0 or 1)
//   o_upd_cnt    completion counter, only with CLK_DIV_CTRL_UPD_CNT_EN defined
//
// Optional feature macro: CLK_DIV_CTRL_UPD_CNT_EN

module clk_div_ctrl #(
  parameter int unsigned RATIO_WD      = 8,
  parameter int unsigned DEFAULT_RATIO = 4,
  parameter int unsigned SETTLE_CYC    = 2
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  ,
  parameter int unsigned CNT_WD        = 8
`endif
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic                i_req_valid,
  input  logic [RATIO_WD-1:0] i_req_ratio,
  output logic                o_req_ready,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy,
  output logic                o_done,
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  output logic [CNT_WD-1:0]   o_upd_cnt,
`endif
  output logic                o_err
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

  localparam logic [RATIO_WD-1:0] RST_RATIO =
    RATIO_WD'(DEFAULT_RATIO);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD,
    SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [RATIO_WD-1:0] pend_q, pend_d;
  logic [RATIO_WD-1:0] drain_q, drain_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= RUN;
      ratio_q  <= RST_RATIO;
      pend_q   <= '0;
      drain_q  <= '0;
      settle_q <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      drain_q  <= drain_d;
      settle_q <= settle_d;
      en_q     <= en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    drain_d  = drain_q;
    settle_d = settle_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        en_d = i_run;
        if (i_req_valid) begin
          if (i_req_ratio < RATIO_WD'(2)) begin
            err_d = 1'b1;
          end else if (i_req_ratio == ratio_q) begin
            done_d = 1'b1;
          end else begin
            // Gate off now; drain one full old period.
            pend_d  = i_req_ratio;
            drain_d = ratio_q;
            en_d    = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Counts down from R_old to 1: exactly R_old cycles.
        if (drain_q <= RATIO_WD'(1)) begin
          state_d = LOAD;
        end else begin
          drain_d = drain_q - RATIO_WD'(1);
        end
      end
      LOAD: begin
        ratio_d  = pend_q;
        settle_d = SW'(SETTLE_CYC);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q <= SW'(1)) begin
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign o_req_ready = (state_q == RUN);
  assign o_busy      = (state_q != RUN);
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = en_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  logic [CNT_WD-1:0] cnt_q;

  // Bumps on the same edge that raises o_done.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (done_d) begin
      cnt_q <= cnt_q + CNT_WD'(1);
    end
  end

  assign o_upd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl
// (DEFAULT_RATIO=4, SETTLE_CYC=2).

module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       vld;
  logic [7:0] rq;
  logic       ready;
  logic [7:0] ratio;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
  logic [7:0] upd;
`endif

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .RATIO_WD      (8),
    .DEFAULT_RATIO (4),
    .SETTLE_CYC    (2)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_run       (run),
    .i_req_valid (vld),
    .i_req_ratio (rq),
    .o_req_ready (ready),
    .o_div_ratio (ratio),
    .o_clk_en    (en),
    .o_busy      (busy),
    .o_done      (done),
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
    .o_upd_cnt   (upd),
`endif
    .o_err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents r for one cycle; returns in cycle T+1.
  task automatic req(input logic [7:0] r);
    vld = 1'b1;
    rq  = r;
    adv(1);
    vld = 1'b0;
  endtask

  task automatic cnt(input string tag, input int exp);
`ifdef CLK_DIV_CTRL_UPD_CNT_EN
    chk(tag, 32'(upd), 32'(exp));
`else
    if (tag.len() < 0) $display("%0d", exp);
`endif
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    vld = 1'b0;
    rq  = '0;
    adv(2);
    chk("rst_ratio", 32'(ratio), 32'd4);
    chk("rst_en",    32'(en),    32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    cnt("rst_cnt", 0);

    rst = 1'b0;
    run = 1'b1;
    chk("en_pre", 32'(en), 32'd0);
    adv(1);
    chk("en_run", 32'(en), 32'd1);

    // Rejected ratios
    req(8'd0);
    chk("err0",       32'(err),   32'd1);
    chk("err0_done",  32'(done),  32'd0);
    chk("err0_ratio", 32'(ratio), 32'd4);
    chk("err0_en",    32'(en),    32'd1);
    adv(1);
    chk("err0_clr",   32'(err),   32'd0);
    req(8'd1);
    chk("err1",       32'(err),   32'd1);
    chk("err1_done",  32'(done),  32'd0);
    chk("err1_ratio", 32'(ratio), 32'd4);
    chk("err1_en",    32'(en),    32'd1);
    adv(1);
    cnt("err_cnt", 0);

    // Same ratio
    req(8'd4);
    chk("same_done", 32'(done), 32'd1);
    chk("same_err",  32'(err),  32'd0);
    chk("same_en",   32'(en),   32'd1);
    chk("same_busy", 32'(busy), 32'd0);
    cnt("same_cnt", 1);
    adv(1);
    chk("same_done1", 32'(done), 32'd0);
    chk("same_en1",   32'(en),   32'd1);

    // 4 -> 6
    req(8'd6);
    chk("r6_en1",    32'(en),    32'd0);
    chk("r6_busy1",  32'(busy),  32'd1);
    chk("r6_ready1", 32'(ready), 32'd0);
    adv(4);
    chk("r6_ratio5", 32'(ratio), 32'd4);
    chk("r6_busy5",  32'(busy),  32'd1);
    adv(1);
    chk("r6_ratio6", 32'(ratio), 32'd6);
    adv(1);
    chk("r6_done7",  32'(done),  32'd0);
    chk("r6_busy7",  32'(busy),  32'd1);
    adv(1);
    chk("r6_done8",  32'(done),  32'd1);
    chk("r6_rdy8",   32'(ready), 32'd1);
    chk("r6_en8",    32'(en),    32'd0);
    chk("r6_err8",   32'(err),   32'd0);
    cnt("r6_cnt", 2);
    adv(1);
    chk("r6_en9",    32'(en),    32'd1);
    chk("r6_done9",  32'(done),  32'd0);

    // 6 -> 8, then 3 held during busy
    vld = 1'b1;
    rq  = 8'd8;
    adv(1);
    rq  = 8'd3;
    chk("b2b_busy1", 32'(busy),  32'd1);
    chk("b2b_rdy1",  32'(ready), 32'd0);
    adv(6);
    chk("b2b_r7",    32'(ratio), 32'd6);
    adv(1);
    chk("b2b_r8",    32'(ratio), 32'd8);
    adv(2);
    chk("b2b_done",  32'(done),  32'd1);
    chk("b2b_rdy",   32'(ready), 32'd1);
    cnt("b2b_cnt", 3);
    adv(1);
    vld = 1'b0;
    chk("b2b_busy2", 32'(busy),  32'd1);
    chk("b2b_en2",   32'(en),    32'd0);
    chk("b2b_done2", 32'(done),  32'd0);
    adv(8);
    chk("b2b_r9",    32'(ratio), 32'd8);
    adv(1);
    chk("b2b_r10",   32'(ratio), 32'd3);
    adv(1);
    chk("b2b_d11",   32'(done),  32'd0);
    adv(1);
    chk("b2b_d12",   32'(done),  32'd1);
    cnt("b2b_cnt2", 4);
    adv(1);
    chk("b2b_en13",  32'(en),    32'd1);

    // 3 -> 4
    req(8'd4);
    adv(6);
    chk("r4_done",   32'(done),  32'd1);
    chk("r4_ratio",  32'(ratio), 32'd4);
    cnt("r4_cnt", 5);
    adv(1);
    chk("r4_en",     32'(en),    32'd1);

    // 4 -> 200 aborted by reset in DRAIN
    req(8'd200);
    adv(2);
    chk("abt_busy",  32'(busy),  32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("abt_ratio", 32'(ratio), 32'd4);
    chk("abt_en",    32'(en),    32'd0);
    chk("abt_busy0", 32'(busy),  32'd0);
    chk("abt_done",  32'(done),  32'd0);
    chk("abt_rdy",   32'(ready), 32'd1);
    cnt("abt_cnt", 0);
    adv(1);
    rst = 1'b0;
    adv(1);
    chk("abt_done1", 32'(done),  32'd0);
    chk("abt_en1",   32'(en),    32'd1);
    chk("abt_r1",    32'(ratio), 32'd4);

    // 4 -> 255, run dropped mid-sequence
    req(8'd255);
    chk("max_busy1", 32'(busy),  32'd1);
    run = 1'b0;
    adv(4);
    chk("max_r5",    32'(ratio), 32'd4);
    chk("max_busy5", 32'(busy),  32'd1);
    adv(1);
    chk("max_r6",    32'(ratio), 32'd255);
    adv(2);
    chk("max_done",  32'(done),  32'd1);
    chk("max_en8",   32'(en),    32'd0);
    cnt("max_cnt", 1);
    adv(1);
    chk("max_en9",   32'(en),    32'd0);
    chk("max_d9",    32'(done),  32'd0);
    run = 1'b1;
    adv(1);
    chk("max_en10",  32'(en),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Ratio/enable controller directly upstream of the programmable clock divider.
- Drives the divider's division-ratio and clock-enable inputs.
- Accepts ratio-change requests over a valid/ready handshake and applies each change glitch-safely: gate the divider off, wait one full old divided period, load the new ratio, settle, then re-enable.
- Rejects ratios the divider cannot divide by (0 and 1).

Parameters:
- RATIO_WD, 8, width of the ratio bus; matches the divider's ratio width.
- DEFAULT_RATIO, 4, ratio driven out of reset; must be >= 2.
- SETTLE_CYC, 2, ref-clock cycles the enable stays low after a new ratio is loaded; must be >= 1.
- CNT_WD, 8, width of the update counter (optional feature only).

Ports:
- i_ref_clk  in  1  reference clock, same clock as the divider.
- i_rst  in  1  reset; asynchronous, active-high.
- i_run  in  1  system request to run the divided clock.
- i_req_valid  in  1  ratio-change request valid.
- i_req_ratio  in  RATIO_WD  requested division ratio.
- o_req_ready  out  1  controller can accept a request.
- o_div_ratio  out  RATIO_WD  ratio to the divider; registered.
- o_clk_en  out  1  enable to the divider; registered.
- o_busy  out  1  ratio change in progress.
- o_done  out  1  one-cycle pulse when a request completes.
- o_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async assert, sync deassert on the ref clock edge):
  - State RUN; o_div_ratio=DEFAULT_RATIO; o_clk_en=0; o_done=o_err=0; pending ratio register cleared.
- States: RUN, DRAIN, LOAD, SETTLE. o_busy=1 in every state except RUN. o_req_ready=1 only in RUN.
- RUN:
  - o_clk_en <= i_run, so o_clk_en follows i_run with 1 cycle of latency.
  - A request is accepted on a clock edge where i_req_valid & o_req_ready = 1. Call that edge T.
- Rejected request: if the accepted ratio is 0 or 1, o_err=1 at T+1. Stay in RUN; ratio and enable are untouched.
- Same ratio: if the accepted ratio equals the current o_div_ratio, o_done=1 at T+1. Stay in RUN; no drain; enable is not disturbed.
- Otherwise:
  - Capture the ratio into the pending register and go to DRAIN.
  - o_clk_en=0 from T+1.
  - Load the drain counter (RATIO_WD bits) with the old o_div_ratio.
- DRAIN: lasts exactly R_old cycles (T+1 .. T+R_old), counting down, then goes to LOAD.
- LOAD:
  - One cycle, at T+R_old+1; o_div_ratio <= pending.
  - The new ratio is visible at T+R_old+2.
- SETTLE:
  - Exactly SETTLE_CYC cycles with o_clk_en=0, then go to RUN.
  - o_done=1 in the first RUN cycle (T+R_old+2+SETTLE_CYC).
  - o_clk_en=i_run from the following cycle.
- i_run deasserting during DRAIN/LOAD/SETTLE does not abort the sequence. i_run is only sampled in RUN.
- i_req_valid held while busy: the request is not accepted. It is accepted on the first RUN cycle, i.e. the same cycle o_done pulses, which allows back-to-back changes.
- i_req_ratio is sampled only at acceptance; later changes are ignored.
- Max ratio 2^RATIO_WD-1: the drain counter must not overflow. Drain length equals the old ratio exactly.
- Reset asserted mid-sequence: immediately return to RUN with DEFAULT_RATIO and o_clk_en=0. The pending request is discarded; no o_done or o_err pulse.
- o_done and o_err are never high in the same cycle.

Optional Feature:
- Macro: CLK_DIV_CTRL_UPD_CNT_EN.
- Defined:
  - Adds output port o_upd_cnt (CNT_WD).
  - Increments on every o_done pulse, including same-ratio completions; does not count o_err.
  - Wraps from 2^CNT_WD-1 to 0.
  - Reset to 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan (DEFAULT_RATIO=4, SETTLE_CYC=2):
- Reset, then i_run=1 -> during reset o_div_ratio=4, o_clk_en=0, o_req_ready=1; o_clk_en=1 one cycle after i_run rises post-reset.
- Request 6 accepted at T -> o_clk_en=0 and o_busy=1 from T+1; o_div_ratio=6 at T+6; o_done=1 and o_req_ready=1 at T+8; o_clk_en=1 at T+9.
- Requests 0 and 1 -> o_err=1 one cycle after each acceptance; o_div_ratio stays 4; o_clk_en stays 1; no o_done.
- Request 4 while the ratio is 4 -> o_done=1 at T+1; o_clk_en never drops; the counter increments if CLK_DIV_CTRL_UPD_CNT_EN is defined.
- Request 8, then i_req_valid held with 3 during busy -> 3 is accepted in the o_done cycle for 8; the second drain lasts 8 cycles; final o_div_ratio=3.
- Reset pulse during DRAIN of a 4->200 change -> o_div_ratio=4, o_clk_en=0, o_busy=0, no o_done; then request 255 -> drain lasts 4 cycles; ratio 255 is loaded correctly.
